sequencer: RTL

SEQUENCER -- requirements
Module: sequencer

---
 rtl/sequencer_pkg.sv | 35 +++
 rtl/sequencer_if.sv | 37 +++
 rtl/sequencer_pc_counter.sv | 30 +++
 rtl/sequencer.sv | 110 +++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared constants for the sequencer slice: bus widths, opcode and phase encodings.
package sequencer_pkg;

    localparam int SEQ_AWIDTH = 5;
    localparam int SEQ_DWIDTH = 8;
    localparam int SEQ_OPW    = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Opcodes whose operand is read from memory and loaded into the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/sequencer_if.sv
// Control/status bundle between the sequencer and its accumulator/memory neighbours.
// The shared data bus is a tristate net and stays a plain inout port on the sequencer.
interface sequencer_if #(
    parameter int AWIDTH = sequencer_pkg::SEQ_AWIDTH,
    parameter int DWIDTH = sequencer_pkg::SEQ_DWIDTH
);
    logic              zero;
    logic [DWIDTH-1:0] ac_out;
    logic [AWIDTH-1:0] addr;
    logic              rd;
    logic              wr;
    logic              ld_ac;
    logic [2:0]        opcode;
    logic              halt;

    modport master (
        input  zero,
        input  ac_out,
        output addr,
        output rd,
        output wr,
        output ld_ac,
        output opcode,
        output halt
    );

    modport slave (
        output zero,
        output ac_out,
        input  addr,
        input  rd,
        input  wr,
        input  ld_ac,
        input  opcode,
        input  halt
    );
endinterface

// File: rtl/sequencer_pc_counter.sv
// Program counter: synchronous reset, load has priority over increment, wraps modulo 2^AWIDTH.
// Latency: new value visible the cycle after the controlling edge; no backpressure.
module pc_counter
    import sequencer_pkg::*;
#(
    parameter int AWIDTH = SEQ_AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [AWIDTH-1:0] i_din,
    output logic [AWIDTH-1:0] o_pc
);

    logic [AWIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_din;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/sequencer.sv
// Eight-phase instruction sequencer: phase FSM, instruction register and memory/ALU strobe decode.
// One phase per clock; strobes are combinational from phase and IR and are squelched while rst is high.
module sequencer
    import sequencer_pkg::*;
#(
    parameter int AWIDTH = SEQ_AWIDTH,
    parameter int DWIDTH = SEQ_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DWIDTH-1:0] data,
    sequencer_if.master       bus
);

    phase_e            r_phase;
    logic [DWIDTH-1:0] r_ir;

    logic [2:0]        w_op;
    logic [AWIDTH-1:0] w_operand;
    logic [AWIDTH-1:0] w_pc;
    logic              w_alu;
    logic              w_sto;
    logic              w_fetch_half;
    logic              w_hlt_hold;
    logic              w_pc_inc;
    logic              w_pc_load;
    logic              w_rd;
    logic              w_wr;
    logic              w_ld;
    logic              w_drive;

    assign w_op      = r_ir[DWIDTH-1:AWIDTH];
    assign w_operand = r_ir[AWIDTH-1:0];
    assign w_alu     = is_aluop(w_op);
    assign w_sto     = (w_op == OP_STO);

    assign w_fetch_half = (r_phase == PH_INST_ADDR) || (r_phase == PH_INST_FETCH) ||
                          (r_phase == PH_INST_LOAD) || (r_phase == PH_IDLE);

    // A halted machine parks in OP_ADDR; only rst moves it on.
    assign w_hlt_hold = (r_phase == PH_OP_ADDR) && (w_op == OP_HLT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_INST_ADDR;
            r_ir    <= '0;
        end else begin
            if ((r_phase == PH_INST_LOAD) || (r_phase == PH_IDLE)) begin
                r_ir <= data;
            end
            if (!w_hlt_hold) begin
                r_phase <= phase_e'(r_phase + 3'd1);
            end
        end
    end

    // zero only matters at the end of ALU_OP, where SKZ adds the second step.
    assign w_pc_inc  = ((r_phase == PH_OP_ADDR) && (w_op != OP_HLT)) ||
                       ((r_phase == PH_ALU_OP) && (w_op == OP_SKZ) && bus.zero);
    assign w_pc_load = (r_phase == PH_ALU_OP) && (w_op == OP_JMP);

    pc_counter #(
        .AWIDTH (AWIDTH)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_pc_load),
        .i_inc  (w_pc_inc),
        .i_din  (w_operand),
        .o_pc   (w_pc)
    );

    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_ld    = 1'b0;
        w_drive = 1'b0;
        if (!rst) begin
            case (r_phase)
                PH_INST_FETCH, PH_INST_LOAD, PH_IDLE: begin
                    w_rd = 1'b1;
                end
                PH_OP_FETCH: begin
                    w_rd = w_alu;
                end
                PH_ALU_OP: begin
                    w_rd    = w_alu;
                    w_drive = w_sto;
                end
                PH_STORE: begin
                    w_rd    = w_alu;
                    w_ld    = w_alu;
                    w_wr    = w_sto;
                    w_drive = w_sto;
                end
                default: begin
                end
            endcase
        end
    end

    assign data       = w_drive ? bus.ac_out : {DWIDTH{1'bz}};
    assign bus.addr   = w_fetch_half ? w_pc : w_operand;
    assign bus.rd     = w_rd;
    assign bus.wr     = w_wr;
    assign bus.ld_ac  = w_ld;
    assign bus.opcode = w_op;
    assign bus.halt   = w_hlt_hold;

endmodule
